sim_ioctl_router: RTL and testbench

Parametrised successor to the fixed download path in the Verilator `emu` top, which uses one target, a hard 14-bit address and `ioctl_wait` tied low. This block routes `ioctl` download bytes to one of `NUM_TARGETS` memories selected by `ioctl_index`, and back-pressures the host through `ioctl_wait` when a target is not ready. It also range-checks addresses and generates the core reset, holding it for a programmable tail after download ends. It sits between the simulated HPS `ioctl_*` inputs and `system`.

---
 rtl/sim_ioctl_router.sv | 152 +++++++++++++++
 tb/tb_sim_ioctl_router.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_ioctl_router.sv
// Routes ioctl download bytes to one of NUM_TARGETS memories and generates the core reset.
// Optional running byte checksum output when IOCTL_CHECKSUM_EN is defined.
module sim_ioctl_router #(
    parameter int NUM_TARGETS = 4,
    parameter int ADDR_W      = 14,
    parameter int INDEX_BASE  = 0,
    parameter int RESET_HOLD  = 16
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   ioctl_download,
    input  logic                   ioctl_wr,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    input  logic [7:0]             ioctl_index,
    output logic                   ioctl_wait,
    output logic [ADDR_W-1:0]      dn_addr,
    output logic [7:0]             dn_data,
    output logic [NUM_TARGETS-1:0] dn_wr,
    input  logic [NUM_TARGETS-1:0] dn_ready,
    output logic                   sys_reset,
    output logic [24:0]            byte_count,
    output logic                   addr_err,
    output logic                   idx_err,
    output logic                   overrun
`ifdef IOCTL_CHECKSUM_EN
    ,
    output logic [7:0]             checksum
`endif
);

    localparam int HOLD_W = $clog2(RESET_HOLD + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, PEND, TAIL} state_t;

    state_t                   state, state_next;
    logic [HOLD_W-1:0]        hold_cnt;
    logic [7:0]               tgt;
    logic [NUM_TARGETS-1:0]   sel_onehot;
    logic                     idx_bad, addr_bad, hit;
    logic                     start, accept, complete, drop_idx, drop_addr, wr_in_pend;

    assign tgt        = ioctl_index - 8'(INDEX_BASE);
    assign idx_bad    = tgt >= 8'(NUM_TARGETS);
    assign addr_bad   = (ioctl_addr >> ADDR_W) != '0;
    assign sel_onehot = NUM_TARGETS'(1) << tgt;
    // dn_wr holds the latched target one-hot, so completion is a plain AND with ready.
    assign hit        = |(dn_wr & dn_ready);
    assign sys_reset  = reset | (state != IDLE);

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        accept     = 1'b0;
        complete   = 1'b0;
        drop_idx   = 1'b0;
        drop_addr  = 1'b0;
        wr_in_pend = 1'b0;
        case (state)
            IDLE: begin
                if (ioctl_download) begin
                    start      = 1'b1;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!ioctl_download) begin
                    state_next = TAIL;
                end else if (ioctl_wr) begin
                    if (idx_bad) begin
                        drop_idx = 1'b1;
                    end else if (addr_bad) begin
                        drop_addr = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = PEND;
                    end
                end
            end
            PEND: begin
                wr_in_pend = ioctl_wr;
                if (hit) begin
                    complete   = 1'b1;
                    state_next = ioctl_download ? ACTIVE : TAIL;
                end
            end
            TAIL: begin
                if (ioctl_download) begin
                    start      = 1'b1;
                    state_next = ACTIVE;
                end else if (hold_cnt == HOLD_W'(RESET_HOLD - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counter is zero on TAIL entry, so TAIL lasts exactly RESET_HOLD cycles.
    always_ff @(posedge clk_sys) begin
        if (reset || state != TAIL) hold_cnt <= '0;
        else                        hold_cnt <= hold_cnt + 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ioctl_wait <= 1'b0;
            dn_wr      <= '0;
            dn_addr    <= '0;
            dn_data    <= '0;
            byte_count <= '0;
            addr_err   <= 1'b0;
            idx_err    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (accept) begin
                ioctl_wait <= 1'b1;
                dn_wr      <= sel_onehot;
                dn_addr    <= ioctl_addr[ADDR_W-1:0];
                dn_data    <= ioctl_dout;
            end else if (complete) begin
                ioctl_wait <= 1'b0;
                dn_wr      <= '0;
            end

            if (start) begin
                byte_count <= '0;
                addr_err   <= 1'b0;
                idx_err    <= 1'b0;
                overrun    <= 1'b0;
            end else begin
                if (complete)   byte_count <= byte_count + 25'd1;
                if (drop_addr)  addr_err   <= 1'b1;
                if (drop_idx)   idx_err    <= 1'b1;
                if (wr_in_pend) overrun    <= 1'b1;
            end
        end
    end

`ifdef IOCTL_CHECKSUM_EN
    always_ff @(posedge clk_sys) begin
        if (reset || start) checksum <= '0;
        else if (complete)  checksum <= checksum + dn_data;
    end
`endif

endmodule

// File: tb/tb_sim_ioctl_router.sv
// Self-checking bench for sim_ioctl_router: vector table, directed corner sequences, random traffic vs scoreboard.
module tb_sim_ioctl_router;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic [13:0] dn_addr;
    logic [7:0]  dn_data;
    logic [3:0]  dn_wr;
    logic [3:0]  dn_ready;
    logic        sys_reset;
    logic [24:0] byte_count;
    logic        addr_err, idx_err, overrun;
`ifdef IOCTL_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    sim_ioctl_router #(
        .NUM_TARGETS(4),
        .ADDR_W(14),
        .INDEX_BASE(0),
        .RESET_HOLD(16)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index),
        .ioctl_wait(ioctl_wait),
        .dn_addr(dn_addr),
        .dn_data(dn_data),
        .dn_wr(dn_wr),
        .dn_ready(dn_ready),
        .sys_reset(sys_reset),
        .byte_count(byte_count),
        .addr_err(addr_err),
        .idx_err(idx_err),
        .overrun(overrun)
`ifdef IOCTL_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  data;
        logic [3:0]  exp_wr;
        logic        exp_ie;
        logic        exp_ae;
    } vec_t;

    typedef struct {
        logic [3:0]  wr;
        logic [13:0] addr;
        logic [7:0]  data;
    } wr_t;

    vec_t vecs[9];
    wr_t  expq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic restart();
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        tick();
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic strobe(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        ioctl_wr    = 1'b1;
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = data;
        tick();
        ioctl_wr    = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          cnt, waitc, wrc, compc, exp_cnt;
        logic        m_ie, m_ae;
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  data;
        int unsigned r;
        wr_t         e;

        //          idx     addr          data   exp_wr   ie    ae
        vecs[0] = '{8'd2,   25'h0000000,  8'hA0, 4'b0100, 1'b0, 1'b0};
        vecs[1] = '{8'd0,   25'h0003FFF,  8'h55, 4'b0001, 1'b0, 1'b0};
        vecs[2] = '{8'd3,   25'h0001234,  8'h3C, 4'b1000, 1'b0, 1'b0};
        vecs[3] = '{8'd4,   25'h0000010,  8'h11, 4'b0000, 1'b1, 1'b0};
        vecs[4] = '{8'd7,   25'h0000000,  8'h22, 4'b0000, 1'b1, 1'b0};
        vecs[5] = '{8'd1,   25'h0004000,  8'h33, 4'b0000, 1'b0, 1'b1};
        vecs[6] = '{8'd1,   25'h1FFFFFF,  8'h44, 4'b0000, 1'b0, 1'b1};
        vecs[7] = '{8'hFF,  25'h0004000,  8'h66, 4'b0000, 1'b1, 1'b0};
        vecs[8] = '{8'd1,   25'h0002AAA,  8'h99, 4'b0010, 1'b0, 1'b0};

        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0; dn_ready = 4'b1111;
        tick(); tick(); tick();
        check("rst_wait", 32'(ioctl_wait), 0);
        check("rst_dn_wr", 32'(dn_wr), 0);
        check("rst_addr_data", {10'd0, dn_addr, dn_data}, 0);
        check("rst_count_flags", {byte_count, addr_err, idx_err, overrun}, 0);
        check("rst_sys_reset", 32'(sys_reset), 1);
        reset = 1'b0;
        #1;
        check("idle_sys_reset", 32'(sys_reset), 0);

        // Table of single-byte downloads.
        foreach (vecs[i]) begin
            restart();
            strobe(vecs[i].idx, vecs[i].addr, vecs[i].data);
            check($sformatf("vec%0d_dn_wr", i), 32'(dn_wr), 32'(vecs[i].exp_wr));
            check($sformatf("vec%0d_wait", i), 32'(ioctl_wait), 32'(vecs[i].exp_wr != 0));
            if (vecs[i].exp_wr != 0)
                check($sformatf("vec%0d_addr_data", i), {10'd0, dn_addr, dn_data},
                      {10'd0, vecs[i].addr[13:0], vecs[i].data});
            tick();
            check($sformatf("vec%0d_dn_wr_off", i), 32'(dn_wr), 0);
            check($sformatf("vec%0d_count", i), 32'(byte_count), 32'(vecs[i].exp_wr != 0));
            check($sformatf("vec%0d_flags", i), {idx_err, addr_err, overrun}, {vecs[i].exp_ie, vecs[i].exp_ae, 1'b0});
        end

        // Four bytes to index 2 at full rate.
        restart();
        for (int k = 0; k < 4; k++) begin
            strobe(8'd2, 25'(k), 8'hA0 + 8'(k));
            check("burst_pulse", {dn_wr, ioctl_wait, 5'd0, dn_addr, dn_data},
                  {4'b0100, 1'b1, 5'd0, 14'(k), 8'hA0 + 8'(k)});
            tick();
            check("burst_pulse_end", {dn_wr, ioctl_wait}, 0);
        end
        check("burst_count", 32'(byte_count), 4);
        check("burst_flags", {addr_err, idx_err, overrun}, 0);

        // Target 1 not ready for 5 cycles.
        restart();
        dn_ready = 4'b1101;
        strobe(8'd1, 25'h10, 8'h5A);
        waitc = 0; wrc = 0; compc = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 5) begin
                dn_ready = 4'b1111;
                #1;
            end
            if (ioctl_wait) waitc++;
            if (dn_wr[1]) wrc++;
            if (dn_wr[1] && dn_ready[1]) compc++;
            tick();
        end
        check("stall_wait_cycles", 32'(waitc), 6);
        check("stall_wr_cycles", 32'(wrc), 6);
        check("stall_completions", 32'(compc), 1);
        check("stall_count", 32'(byte_count), 1);

        // Second strobe while the first is pending.
        restart();
        dn_ready = 4'b1011;
        strobe(8'd2, 25'h20, 8'h11);
        strobe(8'd2, 25'h21, 8'h22);
        check("ovr_flag", 32'(overrun), 1);
        check("ovr_pending_kept", {18'd0, dn_addr, dn_data}, {18'd0, 14'h20, 8'h11});
        dn_ready = 4'b1111;
        tick(); tick(); tick();
        check("ovr_count", 32'(byte_count), 1);

        // Reset tail after download falls.
        restart();
        ioctl_download = 1'b0;
        tick();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!sys_reset) break;
            cnt++;
            tick();
        end
        check("tail_hold", 32'(cnt), 16);

        // Reset during a pending write.
        restart();
        dn_ready = 4'b1110;
        strobe(8'd0, 25'h5, 8'h77);
        check("abort_pending", 32'(dn_wr), 32'(4'b0001));
        reset = 1'b1;
        ioctl_download = 1'b0;
        tick();
        check("abort_outputs", {dn_wr, ioctl_wait, sys_reset}, {4'b0000, 1'b0, 1'b1});
        reset = 1'b0;
        dn_ready = 4'b1111;
        #1;
        check("abort_idle", 32'(sys_reset), 0);

`ifdef IOCTL_CHECKSUM_EN
        restart();
        strobe(8'd0, 25'h0, 8'hFF);
        tick();
        strobe(8'd0, 25'h1, 8'h02);
        tick();
        check("checksum", 32'(checksum), 32'h01);
`endif

        // Random traffic against a transaction-level scoreboard.
        restart();
        m_ie = 1'b0; m_ae = 1'b0; exp_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            dn_ready = (c >= 590) ? 4'b1111 : 4'($urandom);
            if (c < 580 && !ioctl_wait && $urandom_range(1, 0) == 1) begin
                r    = $urandom_range(9, 0);
                idx  = (r == 9) ? 8'hFF : 8'(r);
                addr = ($urandom_range(7, 0) == 0) ? (25'($urandom) | 25'h4000)
                                                   : 25'($urandom_range(16383, 0));
                data = 8'($urandom);
                if (idx >= 8'd4)                 m_ie = 1'b1;
                else if (addr >= 25'd16384)      m_ae = 1'b1;
                else expq.push_back('{4'b0001 << idx, addr[13:0], data});
                ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = addr; ioctl_dout = data;
            end else begin
                ioctl_wr = 1'b0;
            end
            #1;
            if ((dn_wr & dn_ready) != 0) begin
                if (expq.size() == 0) begin
                    check("rand_spurious_write", 32'(dn_wr), 0);
                end else begin
                    e = expq.pop_front();
                    exp_cnt++;
                    check("rand_write", {6'd0, dn_wr, dn_addr, dn_data}, {6'd0, e.wr, e.addr, e.data});
                end
            end
            tick();
        end
        check("rand_drained", 32'(expq.size()), 0);
        check("rand_count", 32'(byte_count), 32'(exp_cnt));
        check("rand_flags", {idx_err, addr_err, overrun}, {m_ie, m_ae, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
